// File: rtl/uart_tx_responder.sv
// uart_tx_responder: accepts bytes from the core's UART send handshake into a
// small FIFO, acknowledges each with a one-cycle uart_send_valid pulse, and
// serialises them onto txd as 8N1 frames (LSB first, idle high).
module uart_tx_responder #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [7:0]                  uart_send_data,
  input  logic                        uart_send_ready,
  output logic                        uart_send_valid,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int CNTW = $clog2(CLK_PER_BIT);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          r_state;
  logic [CNTW-1:0] r_cnt;
  logic [2:0]      r_bitIdx;
  logic [7:0]      r_shift;
  logic            r_txd;
  logic            r_valid;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wrPtr;
  logic [AW-1:0]   r_rdPtr;
  logic [CW-1:0]   r_count;

  state_t          w_stateNext;
  logic [CNTW-1:0] w_cntNext;
  logic [2:0]      w_bitNext;
  logic [7:0]      w_shiftNext;
  logic            w_txdNext;
  logic            w_pop;
  logic            w_push;
  logic            w_full;
  logic            w_baudDone;
  logic            w_notEmpty;

  // Full is judged on the registered count, so a same-cycle pop never frees room early.
  assign w_full     = (r_count == FULL_CNT);
  assign w_notEmpty = (r_count != '0);
  assign w_push     = uart_send_ready && !w_full && !r_valid;
  assign w_baudDone = (r_cnt == LAST_CNT);

  // Next-state, baud counter, shift register and txd value for the frame sequencer.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt + CNTW'(1);
    w_bitNext   = r_bitIdx;
    w_shiftNext = r_shift;
    w_pop       = 1'b0;
    w_txdNext   = 1'b1;
    case (r_state)
      IDLE: begin
        w_cntNext = '0;
        if (w_notEmpty) begin
          w_pop       = 1'b1;
          w_shiftNext = r_mem[r_rdPtr];
          w_stateNext = START;
        end
      end
      START: begin
        if (w_baudDone) begin
          w_cntNext   = '0;
          w_bitNext   = 3'd0;
          w_stateNext = DATA;
        end
      end
      DATA: begin
        if (w_baudDone) begin
          w_cntNext   = '0;
          w_shiftNext = r_shift >> 1;
          if (r_bitIdx == 3'd7) begin
            w_stateNext = STOP;
          end else begin
            w_bitNext = r_bitIdx + 3'd1;
          end
        end
      end
      STOP: begin
        if (w_baudDone) begin
          w_cntNext = '0;
          if (w_notEmpty) begin
            w_pop       = 1'b1;
            w_shiftNext = r_mem[r_rdPtr];
            w_stateNext = START;
          end else begin
            w_stateNext = IDLE;
          end
        end
      end
      default: begin
        w_cntNext   = '0;
        w_stateNext = IDLE;
      end
    endcase
    case (w_stateNext)
      START:   w_txdNext = 1'b0;
      DATA:    w_txdNext = w_shiftNext[0];
      default: w_txdNext = 1'b1;
    endcase
  end

  // Frame sequencer registers; txd comes straight from a flop so the pin never glitches.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
      r_txd    <= 1'b1;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      r_bitIdx <= w_bitNext;
      r_shift  <= w_shiftNext;
      r_txd    <= w_txdNext;
    end
  end

  // FIFO pointers, occupancy count and the one-cycle acknowledge pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_push;
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= uart_send_data;
    end
  end

  assign uart_send_valid = r_valid;
  assign txd             = r_txd;
  assign fifo_count      = r_count;
  assign busy            = (r_state != IDLE) || w_notEmpty;

endmodule

// File: tb/tb_uart_tx_responder.sv
// Directed testbench for uart_tx_responder with CLK_PER_BIT=4 and FIFO_DEPTH=4.
module tb_uart_tx_responder;

  localparam int CLK_PER_BIT  = 4;
  localparam int FIFO_DEPTH   = 4;
  localparam int FRAME_CYCLES = 10 * CLK_PER_BIT;

  logic       clk;
  logic       rstn;
  logic [7:0] sendData;
  logic       sendReady;
  logic       sendValid;
  logic       txd;
  logic       busy;
  logic [2:0] fifoCount;

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;

  uart_tx_responder #(
    .CLK_PER_BIT(CLK_PER_BIT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .uart_send_data (sendData),
    .uart_send_ready(sendReady),
    .uart_send_valid(sendValid),
    .txd            (txd),
    .busy           (busy),
    .fifo_count     (fifoCount)
  );

  // Free-running 100 MHz-style clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to time acknowledges relative to each other.
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Expected txd level at sample i of a frame carrying byte b.
  function automatic logic expTxd(input logic [7:0] b, input int i);
    int idx;
    if (i < CLK_PER_BIT) return 1'b0;
    if (i < 9 * CLK_PER_BIT) begin
      idx = (i - CLK_PER_BIT) / CLK_PER_BIT;
      return b[idx[2:0]];
    end
    return 1'b1;
  endfunction

  // Compliant core handshake: raise ready, wait for the ack, drop ready, confirm a single-cycle ack.
  task automatic applyStimulus(input logic [7:0] b, output int ackCyc, output logic [2:0] ackCount);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    sendData  = b;
    sendReady = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sendValid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    sendReady = 1'b0;
    ackCyc    = cyc;
    ackCount  = fifoCount;
    checkOutput($sformatf("ack 0x%02h", b), 32'(seen), 32'd1);
    @(negedge clk);
    checkOutput($sformatf("validOneCycle 0x%02h", b), 32'(sendValid), 32'd0);
  endtask

  // Check one full frame sample by sample; without waitStart the frame must begin at the very next sample.
  task automatic checkFrame(input logic [7:0] b, input bit waitStart);
    bit started;
    started = 1'b0;
    if (waitStart) begin
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (txd === 1'b0) begin
          started = 1'b1;
          break;
        end
      end
      checkOutput($sformatf("frameStart 0x%02h", b), 32'(started), 32'd1);
      if (!started) return;
    end else begin
      @(negedge clk);
    end
    for (int i = 0; i < FRAME_CYCLES; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput($sformatf("txd 0x%02h s%0d", b, i), 32'(txd), 32'(expTxd(b, i)));
      if (i == FRAME_CYCLES - 1) checkOutput($sformatf("busyLastSample 0x%02h", b), 32'(busy), 32'd1);
    end
  endtask

  int         ackCycA [5];
  logic [2:0] ackCntA [5];
  int         fillCyc [7];
  int         gapExp  [6] = '{2, 2, 2, 2, 34, 40};
  logic [2:0] cntAtSixth;
  int         maxCnt;
  bit         backToBack;
  bit         prevValid;
  bit         got;
  bit         started;
  int         activity;
  int         dummyCyc;
  logic [2:0] dummyCnt;

  initial begin
    rstn      = 1'b0;
    sendReady = 1'b0;
    sendData  = 8'h00;

    // Test 1: reset values and a quiet line afterwards.
    @(negedge clk);
    checkOutput("rst txd", 32'(txd), 32'd1);
    checkOutput("rst valid", 32'(sendValid), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst count", 32'(fifoCount), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    activity = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || sendValid !== 1'b0) activity++;
    end
    checkOutput("idleQuiet", 32'(activity), 32'd0);

    // Test 2: single byte 0xA5.
    fork
      applyStimulus(8'hA5, dummyCyc, dummyCnt);
      checkFrame(8'hA5, 1'b1);
    join
    @(negedge clk);
    checkOutput("t2 busyFell", 32'(busy), 32'd0);
    checkOutput("t2 txdIdle", 32'(txd), 32'd1);
    checkOutput("t2 count", 32'(fifoCount), 32'd0);

    // Test 3: five bytes back-to-back, frames contiguous and in order.
    fork
      begin
        for (int n = 0; n < 5; n++) applyStimulus(8'h01 + 8'(n), ackCycA[n], ackCntA[n]);
      end
      begin
        checkFrame(8'h01, 1'b1);
        for (int n = 1; n < 5; n++) checkFrame(8'h01 + 8'(n), 1'b0);
      end
    join
    for (int n = 1; n < 5; n++) checkOutput($sformatf("t3 ackGap%0d", n), 32'(ackCycA[n] - ackCycA[n-1]), 32'd3);
    checkOutput("t3 countAt4th", 32'(ackCntA[3]), 32'd3);
    checkOutput("t3 countAt5th", 32'(ackCntA[4]), 32'd4);
    @(negedge clk);
    checkOutput("t3 busyFell", 32'(busy), 32'd0);
    checkOutput("t3 txdIdle", 32'(txd), 32'd1);

    // Tests 4 and 6: ready held high fills the FIFO; pending request is taken the edge after a STOP-end pop.
    maxCnt     = 0;
    backToBack = 1'b0;
    prevValid  = 1'b0;
    cntAtSixth = '0;
    fork
      begin
        @(negedge clk);
        sendData  = 8'h10;
        sendReady = 1'b1;
        for (int n = 0; n < 7; n++) begin
          got = 1'b0;
          for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sendValid === 1'b1) begin
              got = 1'b1;
              break;
            end
          end
          checkOutput($sformatf("t4 ack%0d", n), 32'(got), 32'd1);
          fillCyc[n] = cyc;
          if (n == 5) cntAtSixth = fifoCount;
          sendData = 8'h11 + 8'(n);
          if (n == 6) sendReady = 1'b0;
        end
      end
      begin
        checkFrame(8'h10, 1'b1);
        for (int n = 1; n < 7; n++) checkFrame(8'h10 + 8'(n), 1'b0);
      end
      begin
        for (int k = 0; k < 330; k++) begin
          @(negedge clk);
          if (sendValid === 1'b1 && prevValid) backToBack = 1'b1;
          if (int'(fifoCount) > maxCnt) maxCnt = int'(fifoCount);
          prevValid = (sendValid === 1'b1);
        end
      end
    join
    for (int n = 1; n < 7; n++) checkOutput($sformatf("t4 ackGap%0d", n), 32'(fillCyc[n] - fillCyc[n-1]), 32'(gapExp[n-1]));
    checkOutput("t6 countAfterRefill", 32'(cntAtSixth), 32'd4);
    checkOutput("t4 maxCount", 32'(maxCnt), 32'd4);
    checkOutput("t4 validBackToBack", 32'(backToBack), 32'd0);
    checkOutput("t4 drained", 32'(fifoCount), 32'd0);

    // Test 5: reset during DATA bit 3 of 0x3C with two bytes queued.
    fork
      begin
        applyStimulus(8'h3C, dummyCyc, dummyCnt);
        applyStimulus(8'h11, dummyCyc, dummyCnt);
        applyStimulus(8'h22, dummyCyc, dummyCnt);
      end
      begin
        started = 1'b0;
        for (int k = 0; k < 300; k++) begin
          @(negedge clk);
          if (txd === 1'b0) begin
            started = 1'b1;
            break;
          end
        end
        checkOutput("t5 start", 32'(started), 32'd1);
        repeat (17) @(negedge clk);
        checkOutput("t5 bit3", 32'(txd), 32'd1);
        checkOutput("t5 queued", 32'(fifoCount), 32'd2);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        checkOutput("t5 txd", 32'(txd), 32'd1);
        checkOutput("t5 count", 32'(fifoCount), 32'd0);
        checkOutput("t5 busy", 32'(busy), 32'd0);
        checkOutput("t5 valid", 32'(sendValid), 32'd0);
        activity = 0;
        repeat (100) begin
          @(negedge clk);
          if (txd !== 1'b1 || busy !== 1'b0) activity++;
        end
        checkOutput("t5 quiet", 32'(activity), 32'd0);
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
